// File: rtl/rad_async_fifo_pkg.sv
// Shared pointer helpers for the async FIFO: Gray/binary conversion and default sizing.
// Functions work on a 32-bit container; callers zero-extend and slice to their pointer width.
package rad_async_fifo_pkg;

    localparam int DEFAULT_ADDRSIZE = 3;
    localparam int PTR_MAXW         = 32;

    function automatic logic [PTR_MAXW-1:0] bin2gray(input logic [PTR_MAXW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [PTR_MAXW-1:0] gray2bin(input logic [PTR_MAXW-1:0] g);
        logic [PTR_MAXW-1:0] b;
        b = g;
        for (int i = 1; i < PTR_MAXW; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/rad_async_fifo_sync2.sv
// Two-flop synchronizer bringing a Gray pointer into the local clock domain.
// Latency: 2 wclk edges from d to q.
// Backpressure: none; samples every edge.
module rad_async_fifo_sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q1;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            q1 <= '0;
            q  <= '0;
        end else begin
            q1 <= d;
            q  <= q1;
        end
    end

endmodule

// File: rtl/rad_async_fifo_wptr_full.sv
// Async FIFO write-side pointer, full/overflow/occupancy logic; walmost_full under RAD_ASYNC_FIFO_WALMOST_FULL_EN.
// Latency: wptr/wfull registered 1 edge after winc; read pointer seen after 2-flop sync.
// Backpressure: wclken drops while wfull is high; writes attempted while full set sticky wovf.
module rad_async_fifo_wptr_full
    import rad_async_fifo_pkg::*;
#(
    parameter int ADDRSIZE    = DEFAULT_ADDRSIZE,
    parameter int AFULL_LEVEL = 6
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE:0]   wptr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic                wclken,
    output logic                wfull,
    output logic [ADDRSIZE:0]   wcount,
    output logic                wovf,
    output logic                walmost_full
);

    logic [ADDRSIZE:0]   wbin;
    logic [ADDRSIZE:0]   wbin_next;
    logic [ADDRSIZE:0]   wgray_next;
    logic [ADDRSIZE:0]   wq2_rptr;
    logic [ADDRSIZE:0]   rbin_sync;
    logic [ADDRSIZE:0]   wfull_match;
    logic [PTR_MAXW-1:0] gray_ext;
    logic [PTR_MAXW-1:0] rbin_ext;
    logic                unused_ext_bits;

    rad_async_fifo_sync2 #(.WIDTH(ADDRSIZE + 1)) u_rptr_sync (
        .wclk (wclk),
        .wrst (wrst),
        .d    (rptr),
        .q    (wq2_rptr)
    );

    assign wclken     = winc & ~wfull;
    assign wbin_next  = wbin + {{ADDRSIZE{1'b0}}, wclken};
    assign gray_ext   = bin2gray(PTR_MAXW'(wbin_next));
    assign wgray_next = gray_ext[ADDRSIZE:0];
    assign rbin_ext   = gray2bin(PTR_MAXW'(wq2_rptr));
    assign rbin_sync  = rbin_ext[ADDRSIZE:0];
    assign unused_ext_bits = ^{gray_ext[PTR_MAXW-1:ADDRSIZE+1], rbin_ext[PTR_MAXW-1:ADDRSIZE+1]};

    // Full when the next write pointer is exactly one lap ahead of the synced read pointer.
    assign wfull_match = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};

    assign waddr  = wbin[ADDRSIZE-1:0];
    assign wcount = wbin - rbin_sync;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin  <= '0;
            wptr  <= '0;
            wfull <= 1'b0;
            wovf  <= 1'b0;
        end else begin
            wbin  <= wbin_next;
            wptr  <= wgray_next;
            wfull <= (wgray_next == wfull_match);
            if (winc && wfull) begin
                wovf <= 1'b1;
            end
        end
    end

`ifdef RAD_ASYNC_FIFO_WALMOST_FULL_EN
    logic [ADDRSIZE:0] afull_cnt;
    assign afull_cnt = wbin_next - rbin_sync;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            walmost_full <= 1'b0;
        end else begin
            walmost_full <= (32'(afull_cnt) >= 32'(AFULL_LEVEL));
        end
    end
`else
    localparam int unused_afull_level = AFULL_LEVEL;
    assign walmost_full = 1'b0;
`endif

endmodule

// File: tb/tb_rad_async_fifo_wptr_full.sv
// Directed bench for the async FIFO write side: count-based reference model plus literal spot checks.
module tb_rad_async_fifo_wptr_full;

    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AFULL = 6;

    logic          wclk = 1'b0;
    logic          wrst = 1'b0;
    logic          winc = 1'b0;
    logic [AW:0]   rptr = '0;
    logic [AW:0]   wptr;
    logic [AW-1:0] waddr;
    logic          wclken;
    logic          wfull;
    logic [AW:0]   wcount;
    logic          wovf;
    logic          walmost_full;

    rad_async_fifo_wptr_full #(.ADDRSIZE(AW), .AFULL_LEVEL(AFULL)) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .winc         (winc),
        .rptr         (rptr),
        .wptr         (wptr),
        .waddr        (waddr),
        .wclken       (wclken),
        .wfull        (wfull),
        .wcount       (wcount),
        .wovf         (wovf),
        .walmost_full (walmost_full)
    );

    always #5 wclk = ~wclk;

    int n_vec = 0;
    int n_bad = 0;

    // Model state: total words written, and total words read as seen through the two sync stages.
    int rcnt  = 0;
    int m_w   = 0;
    int m_rs1 = 0;
    int m_rs2 = 0;
    bit m_full  = 1'b0;
    bit m_ovf   = 1'b0;
    bit m_af    = 1'b0;
    bit m_valid = 1'b0;

    int gseq[8] = '{1, 3, 2, 6, 7, 5, 4, 12};

    function automatic logic [AW:0] gray_of(input int n);
        logic [AW:0] b;
        b = n[AW:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    always @(posedge wclk) begin
        if (wrst) begin
            m_w     <= 0;
            m_rs1   <= 0;
            m_rs2   <= 0;
            m_full  <= 1'b0;
            m_ovf   <= 1'b0;
            m_af    <= 1'b0;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            m_w    <= m_w + int'(winc && !m_full);
            m_full <= (m_w + int'(winc && !m_full) - m_rs2) == DEPTH;
            m_ovf  <= m_ovf || (winc && m_full);
`ifdef RAD_ASYNC_FIFO_WALMOST_FULL_EN
            m_af   <= (m_w + int'(winc && !m_full) - m_rs2) >= AFULL;
`else
            m_af   <= 1'b0;
`endif
            m_rs1  <= rcnt;
            m_rs2  <= m_rs1;
        end
    end

    always @(negedge wclk) begin
        if (m_valid) begin
            chk("m_wptr",   int'(wptr),         int'(gray_of(m_w)));
            chk("m_waddr",  int'(waddr),        m_w % DEPTH);
            chk("m_wclken", int'(wclken),       int'(winc && !m_full));
            chk("m_wfull",  int'(wfull),        int'(m_full));
            chk("m_wcount", int'(wcount),       m_w - m_rs2);
            chk("m_wovf",   int'(wovf),         int'(m_ovf));
            chk("m_afull",  int'(walmost_full), int'(m_af));
        end
    end

    task automatic tick(input logic r, input logic i, input int rc);
        wrst = r;
        winc = i;
        rcnt = rc;
        rptr = gray_of(rc);
        @(posedge wclk);
        #2;
    endtask

    initial begin
        tick(1'b1, 1'b0, 0);
        tick(1'b1, 1'b0, 0);
        chk("rst_wptr",   int'(wptr),   0);
        chk("rst_wcount", int'(wcount), 0);
        chk("rst_wfull",  int'(wfull),  0);
        chk("rst_wovf",   int'(wovf),   0);

        // Fill to full with the reader idle.
        for (int i = 0; i < 8; i++) begin
            chk("fill_waddr", int'(waddr), i);
            tick(1'b0, 1'b1, 0);
            chk("fill_wptr", int'(wptr), gseq[i]);
        end
        chk("full_wfull",  int'(wfull),  1);
        chk("full_wcount", int'(wcount), 8);
        chk("full_wclken", int'(wclken), 0);

        // Writes while full must not move the pointer.
        tick(1'b0, 1'b1, 0);
        tick(1'b0, 1'b1, 0);
        chk("ovf_wptr", int'(wptr), 12);
        chk("ovf_wovf", int'(wovf), 1);
        tick(1'b0, 1'b0, 0);
        chk("ovf_sticky", int'(wovf), 1);

        // Reader frees three entries; full clears only after the sync delay.
        tick(1'b0, 1'b0, 3);
        chk("free_t1_wfull", int'(wfull), 1);
        tick(1'b0, 1'b0, 3);
        chk("free_t2_wfull", int'(wfull), 1);
        tick(1'b0, 1'b0, 3);
        chk("free_t3_wfull",  int'(wfull),  0);
        chk("free_t3_wcount", int'(wcount), 5);

        // Two full laps of the pointer with the reader trailing closely.
        tick(1'b1, 1'b0, 0);
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, 1'b1, i);
            chk("wrap_wfull", int'(wfull), 0);
        end
        chk("wrap_wptr",  int'(wptr),  0);
        chk("wrap_waddr", int'(waddr), 0);
        chk("wrap_wovf",  int'(wovf),  0);
        tick(1'b0, 1'b0, 16);
        tick(1'b0, 1'b0, 16);
        tick(1'b0, 1'b0, 16);
        chk("wrap_drain_wcount", int'(wcount), 0);

        // Almost-full threshold.
        tick(1'b1, 1'b0, 0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 0);
        chk("af_5", int'(walmost_full), 0);
        tick(1'b0, 1'b1, 0);
`ifdef RAD_ASYNC_FIFO_WALMOST_FULL_EN
        chk("af_6", int'(walmost_full), 1);
`else
        chk("af_6", int'(walmost_full), 0);
`endif

        // Reset wins over a concurrent write.
        tick(1'b1, 1'b0, 0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 0);
        chk("pre_rst_wptr", int'(wptr), 7);
        tick(1'b1, 1'b1, 0);
        chk("mid_rst_wptr",   int'(wptr),   0);
        chk("mid_rst_waddr",  int'(waddr),  0);
        chk("mid_rst_wfull",  int'(wfull),  0);
        chk("mid_rst_wovf",   int'(wovf),   0);
        chk("mid_rst_wcount", int'(wcount), 0);
        tick(1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
